row_requestor_rr: RTL and testbench
===================================

Name: row_requestor_rr

Overview:
Parametrised successor of the single-channel row/column request generator. It walks a frame row by row and, within each row, over the enabled columns. For each (row, column) it emits one read request (beat-aligned address, beat count, start/end byte lanes) plus the packed write-side address. Each request goes to one of NUM_TRID transaction trackers, chosen by a round-robin arbiter over their ready flags; it sits between the config registers and the tracker array of the relational cache.

Parameters:
NUM_TRID, 16, number of trackers (≥2, power of two)
NUM_COLUMNS, 11, max configurable columns
ADDR_W, 32, address width
BUS_BYTES, 16, bytes per bus beat (power of two); LANE_W = log2(BUS_BYTES)
COL_W, 16, column width/offset field width (bytes)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_abort  in  1  software abort; same effect as i_rst, synchronous
i_start  in  1  pulse; start walk when idle
i_frame_base  in  ADDR_W  frame base byte address
i_row_size  in  ADDR_W  row stride in bytes
i_row_cnt  in  ADDR_W  rows to walk
i_col_width  in  NUM_COLUMNS*COL_W  per-column width in bytes
i_col_offset  in  NUM_COLUMNS*COL_W  per-column byte offset in row
i_col_en  in  NUM_COLUMNS  enabled-column mask
i_ready  in  NUM_TRID  tracker ready flags
o_en  out  NUM_TRID  one-hot issue strobe, 1 cycle
o_r_addr  out  ADDR_W  beat-aligned read address
o_r_size  out  COL_W+1  beats to read
o_r_start  out  LANE_W  first valid byte lane
o_r_end  out  LANE_W  last valid byte lane in final beat
o_w_addr  out  ADDR_W  packed output byte address
o_w_size  out  COL_W  bytes written (= column width)
o_busy  out  1  walk in progress
o_done  out  1  1-cycle pulse at walk completion

Behaviour:
- Reset or i_abort: state IDLE; all outputs 0; RR pointer 0; counters cleared. Takes effect the same cycle regardless of state. Any in-flight walk is dropped with no o_done.
- FSM: IDLE -> LOAD -> CALC -> ISSUE -> (CALC | DONE) -> IDLE.
- IDLE: i_start=1 -> LOAD. o_busy=0.
- LOAD (1 cycle): latch all config inputs; later config changes are ignored until the next start. row_base=frame_base, row=0, w_ptr=0, col = lowest set bit of col_en.
  - If row_cnt==0 or col_en==0 -> DONE, with no requests issued.
- CALC (1 cycle): a = row_base + offset[col], mod 2^ADDR_W.
  - r_addr = a with low LANE_W bits cleared; r_start = a[LANE_W-1:0].
  - last = r_start + width - 1; r_size = (last >> LANE_W) + 1; r_end = last[LANE_W-1:0].
  - width==0 is treated as width 1.
- ISSUE: hold registered request fields stable.
  - If |i_ready: grant the first ready tracker at or after rr_ptr, cyclic; pulse o_en[g]=1 for one cycle; rr_ptr <= g+1 mod NUM_TRID.
  - Else wait, with fields unchanged.
- After a grant:
  - w_ptr += width.
  - col = next set bit above col.
  - If none: row++, row_base += row_size (adder, no multiplier), col = lowest set bit.
  - If row == row_cnt: DONE, else CALC.
- DONE: o_done=1 for one cycle -> IDLE.
- o_w_addr = w_ptr at issue, starting at 0 and packed contiguously across rows.
- o_busy=1 in LOAD/CALC/ISSUE/DONE.
- i_start while busy is ignored.
- Minimum 2 cycles per request (CALC + ISSUE).
- o_en is at most one-hot, and is 0 outside ISSUE.

Decomposition:
- Package rreq_pkg: FSM state enum; localparam LANE_W=$clog2(BUS_BYTES); request field struct (r_addr, r_size, r_start, r_end, w_addr, w_size).
- Sub-module rr_arbiter #(N): i_req, i_ptr -> o_grant_onehot, o_grant_idx, o_valid; purely combinational.

Test Plan:
- BUS_BYTES=16, base 0x1000, row_size 64, row_cnt 2, col_en=0b101, off0=4/w0=8, off2=20/w2=16, i_ready all 1 -> four requests in order:
  - (0x1000, size1, s4, e11, w0)
  - (0x1010, size2, s4, e3, w8)
  - (0x1040, size1, s4, e11, w24)
  - (0x1050, size2, s4, e3, w32)
  - then o_done pulses once.
- Round-robin: i_ready=0b1010 held, rr_ptr=0 -> grants go to trackers 1, 3, 1, 3; each o_en is a single-cycle one-hot pulse.
- Backpressure: i_ready=0 for 5 cycles in ISSUE -> no o_en and request fields stable; setting i_ready[7]=1 -> o_en[7] in that cycle.
- Degenerate configs: row_cnt=0 -> o_done exactly 3 cycles after i_start with no o_en. col_en=0 -> same behaviour.
- i_abort asserted after 2nd grant -> next cycle all outputs 0, o_busy=0, no o_done; a new i_start restarts from row 0 with w_addr 0.
- Wrap and re-start: base 0xFFFF_FFF0, off 0x18 -> r_addr 0x0000_0000, start 8. An i_start pulse mid-walk -> ignored, walk completes unchanged.

Source files
------------

// File: rtl/rreq_pkg.sv
// Shared types for the row/column read-request generator: FSM states and the
// registered request record that is presented to the tracker array.
package rreq_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int COL_W_DEF     = 16;
    localparam int BUS_BYTES_DEF = 16;
    localparam int LANE_W        = $clog2(BUS_BYTES_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_ISSUE,
        ST_DONE
    } state_t;

    // Request record is sized by the package widths; the top-level width
    // parameters are expected to stay at these values.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] r_addr;
        logic [COL_W_DEF:0]    r_size;
        logic [LANE_W-1:0]     r_start;
        logic [LANE_W-1:0]     r_end;
        logic [ADDR_W_DEF-1:0] w_addr;
        logic [COL_W_DEF-1:0]  w_size;
    } req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// i_ptr, wrapping cyclically. N must be a power of two.
module rr_arbiter #(
    parameter int N = 16
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant_onehot,
    output logic [$clog2(N)-1:0] o_grant_idx,
    output logic                 o_valid
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        o_valid        = 1'b0;
        cand           = '0;
        // Index arithmetic wraps for free because N is a power of two.
        for (int i = 0; i < N; i++) begin
            cand = i_ptr + IW'(i);
            if (!o_valid && i_req[cand]) begin
                o_valid     = 1'b1;
                o_grant_idx = cand;
            end
        end
        if (o_valid) begin
            o_grant_onehot[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/row_requestor_rr.sv
// Walks a frame row by row over the enabled columns, emitting one beat-aligned
// read request per (row, column) to a round-robin-selected transaction tracker.
module row_requestor_rr
    import rreq_pkg::*;
#(
    parameter int NUM_TRID    = 16,
    parameter int NUM_COLUMNS = 11,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int BUS_BYTES   = BUS_BYTES_DEF,
    parameter int COL_W       = COL_W_DEF
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_abort,
    input  logic                           i_start,
    input  logic [ADDR_W-1:0]              i_frame_base,
    input  logic [ADDR_W-1:0]              i_row_size,
    input  logic [ADDR_W-1:0]              i_row_cnt,
    input  logic [NUM_COLUMNS*COL_W-1:0]   i_col_width,
    input  logic [NUM_COLUMNS*COL_W-1:0]   i_col_offset,
    input  logic [NUM_COLUMNS-1:0]         i_col_en,
    input  logic [NUM_TRID-1:0]            i_ready,
    output logic [NUM_TRID-1:0]            o_en,
    output logic [ADDR_W-1:0]              o_r_addr,
    output logic [COL_W:0]                 o_r_size,
    output logic [$clog2(BUS_BYTES)-1:0]   o_r_start,
    output logic [$clog2(BUS_BYTES)-1:0]   o_r_end,
    output logic [ADDR_W-1:0]              o_w_addr,
    output logic [COL_W-1:0]               o_w_size,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int LW     = $clog2(BUS_BYTES);
    localparam int PTR_W  = $clog2(NUM_TRID);
    localparam int CIDX_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
    localparam int LAST_W = COL_W + 1;

    state_t                 state_reg;
    logic [ADDR_W-1:0]      row_size_reg;
    logic [ADDR_W-1:0]      row_cnt_reg;
    logic [ADDR_W-1:0]      row_reg;
    logic [ADDR_W-1:0]      row_base_reg;
    logic [ADDR_W-1:0]      w_ptr_reg;
    logic [COL_W-1:0]       width_reg  [NUM_COLUMNS];
    logic [COL_W-1:0]       offset_reg [NUM_COLUMNS];
    logic [NUM_COLUMNS-1:0] col_en_reg;
    logic [CIDX_W-1:0]      col_reg;
    logic [PTR_W-1:0]       rr_ptr_reg;
    req_t                   req_reg;
    logic                   done_reg;

    logic [COL_W-1:0]       width_in  [NUM_COLUMNS];
    logic [COL_W-1:0]       offset_in [NUM_COLUMNS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLUMNS; gi++) begin : g_unpack
            assign width_in[gi]  = i_col_width[gi*COL_W +: COL_W];
            assign offset_in[gi] = i_col_offset[gi*COL_W +: COL_W];
        end
    endgenerate

    // Lowest set bit of mask at index >= from; returns 1 when one exists.
    function automatic logic find_bit(input logic [NUM_COLUMNS-1:0] mask,
                                      input int from,
                                      output logic [CIDX_W-1:0] idx);
        logic found;
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_COLUMNS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                found = 1'b1;
                idx   = CIDX_W'(i);
            end
        end
        return found;
    endfunction

    logic [NUM_COLUMNS-1:0] first_src;
    logic                   first_found;
    logic [CIDX_W-1:0]      first_col;
    logic                   nxt_found;
    logic [CIDX_W-1:0]      nxt_col;
    logic [COL_W-1:0]       eff_width;
    logic [ADDR_W-1:0]      addr_sum;
    logic [LAST_W-1:0]      last_byte;
    logic [LAST_W-1:0]      beats;

    always_comb begin
        first_src   = (state_reg == ST_LOAD) ? i_col_en : col_en_reg;
        first_found = find_bit(first_src, 0, first_col);
        nxt_found   = find_bit(col_en_reg, int'(col_reg) + 1, nxt_col);
        eff_width   = (width_reg[col_reg] == '0) ? COL_W'(1) : width_reg[col_reg];
        addr_sum    = row_base_reg + ADDR_W'(offset_reg[col_reg]);
        last_byte   = LAST_W'(addr_sum[LW-1:0]) + LAST_W'(eff_width) - LAST_W'(1);
        beats       = (last_byte >> LW) + LAST_W'(1);
    end

    logic [NUM_TRID-1:0] grant_onehot;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_valid;

    rr_arbiter #(
        .N(NUM_TRID)
    ) u_arb (
        .i_req          (i_ready),
        .i_ptr          (rr_ptr_reg),
        .o_grant_onehot (grant_onehot),
        .o_grant_idx    (grant_idx),
        .o_valid        (grant_valid)
    );

    logic issue_fire;
    assign issue_fire = (state_reg == ST_ISSUE) && grant_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_abort) begin
            state_reg    <= ST_IDLE;
            row_size_reg <= '0;
            row_cnt_reg  <= '0;
            row_reg      <= '0;
            row_base_reg <= '0;
            w_ptr_reg    <= '0;
            col_en_reg   <= '0;
            col_reg      <= '0;
            rr_ptr_reg   <= '0;
            req_reg      <= '0;
            done_reg     <= 1'b0;
            for (int i = 0; i < NUM_COLUMNS; i++) begin
                width_reg[i]  <= '0;
                offset_reg[i] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    row_size_reg <= i_row_size;
                    row_cnt_reg  <= i_row_cnt;
                    col_en_reg   <= i_col_en;
                    row_base_reg <= i_frame_base;
                    row_reg      <= '0;
                    w_ptr_reg    <= '0;
                    col_reg      <= first_col;
                    for (int i = 0; i < NUM_COLUMNS; i++) begin
                        width_reg[i]  <= width_in[i];
                        offset_reg[i] <= offset_in[i];
                    end
                    if ((i_row_cnt == '0) || !first_found) begin
                        state_reg <= ST_DONE;
                    end else begin
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    req_reg.r_addr  <= {addr_sum[ADDR_W-1:LW], {LW{1'b0}}};
                    req_reg.r_start <= addr_sum[LW-1:0];
                    req_reg.r_end   <= last_byte[LW-1:0];
                    req_reg.r_size  <= beats;
                    req_reg.w_addr  <= w_ptr_reg;
                    req_reg.w_size  <= eff_width;
                    state_reg       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (issue_fire) begin
                        rr_ptr_reg <= grant_idx + PTR_W'(1);
                        w_ptr_reg  <= w_ptr_reg + ADDR_W'(eff_width);
                        if (nxt_found) begin
                            col_reg   <= nxt_col;
                            state_reg <= ST_CALC;
                        end else begin
                            // Row finished: step the base by the stride, no multiply.
                            col_reg      <= first_col;
                            row_reg      <= row_reg + ADDR_W'(1);
                            row_base_reg <= row_base_reg + row_size_reg;
                            if ((row_reg + ADDR_W'(1)) == row_cnt_reg) begin
                                state_reg <= ST_DONE;
                            end else begin
                                state_reg <= ST_CALC;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // The issue strobe follows i_ready within the ISSUE cycle itself.
    assign o_en      = issue_fire ? grant_onehot : '0;
    assign o_r_addr  = req_reg.r_addr;
    assign o_r_size  = req_reg.r_size;
    assign o_r_start = req_reg.r_start;
    assign o_r_end   = req_reg.r_end;
    assign o_w_addr  = req_reg.w_addr;
    assign o_w_size  = req_reg.w_size;
    assign o_busy    = (state_reg != ST_IDLE);
    assign o_done    = done_reg;

endmodule

// File: tb/tb_row_requestor_rr.sv
// Directed bench for row_requestor_rr: table of expected requests per walk,
// plus hand-written sequences for backpressure, abort, degenerate and wrap cases.
module tb_row_requestor_rr;

    logic          clk;
    logic          i_rst;
    logic          i_abort;
    logic          i_start;
    logic [31:0]   i_frame_base;
    logic [31:0]   i_row_size;
    logic [31:0]   i_row_cnt;
    logic [175:0]  i_col_width;
    logic [175:0]  i_col_offset;
    logic [10:0]   i_col_en;
    logic [15:0]   i_ready;
    logic [15:0]   o_en;
    logic [31:0]   o_r_addr;
    logic [16:0]   o_r_size;
    logic [3:0]    o_r_start;
    logic [3:0]    o_r_end;
    logic [31:0]   o_w_addr;
    logic [15:0]   o_w_size;
    logic          o_busy;
    logic          o_done;

    row_requestor_rr dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_abort      (i_abort),
        .i_start      (i_start),
        .i_frame_base (i_frame_base),
        .i_row_size   (i_row_size),
        .i_row_cnt    (i_row_cnt),
        .i_col_width  (i_col_width),
        .i_col_offset (i_col_offset),
        .i_col_en     (i_col_en),
        .i_ready      (i_ready),
        .o_en         (o_en),
        .o_r_addr     (o_r_addr),
        .o_r_size     (o_r_size),
        .o_r_start    (o_r_start),
        .o_r_end      (o_r_end),
        .o_w_addr     (o_w_addr),
        .o_w_size     (o_w_size),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r_addr;
        logic [16:0] r_size;
        logic [3:0]  r_start;
        logic [3:0]  r_end;
        logic [31:0] w_addr;
        logic [15:0] w_size;
        logic [15:0] en;
    } req_rec_t;

    int        errors = 0;
    int        checks = 0;
    int        en_count = 0;
    int        done_count = 0;
    logic      prev_en_nz = 1'b0;
    req_rec_t  got[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue monitor: one line per accepted request.
    always @(negedge clk) begin
        if (o_en != '0) begin
            check("en_onehot", 64'($onehot(o_en)), 64'd1);
            check("en_single_cycle", 64'(prev_en_nz), 64'd0);
            got.push_back('{o_r_addr, o_r_size, o_r_start, o_r_end, o_w_addr, o_w_size, o_en});
            en_count++;
            $display("issue en=%04h r_addr=%08h size=%0d start=%0d end=%0d w_addr=%0d w_size=%0d",
                     o_en, o_r_addr, o_r_size, o_r_start, o_r_end, o_w_addr, o_w_size);
        end
        prev_en_nz = (o_en != '0);
        if (o_done) done_count++;
    end

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic configure(input logic [31:0] base, input logic [31:0] rsz,
                             input logic [31:0] rcnt, input logic [15:0] off0,
                             input logic [15:0] w0, input logic [15:0] off2,
                             input logic [15:0] w2, input logic [10:0] en);
        i_frame_base          = base;
        i_row_size            = rsz;
        i_row_cnt             = rcnt;
        i_col_offset          = '0;
        i_col_width           = '0;
        i_col_offset[15:0]    = off0;
        i_col_width[15:0]     = w0;
        i_col_offset[47:32]   = off2;
        i_col_width[47:32]    = w2;
        i_col_en              = en;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!o_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(name, 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_en_count(input int target, input string name);
        int n = 0;
        while (en_count < target && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) check(name, 64'(en_count), 64'(target));
    endtask

    task automatic cmp_req(input string tag, input int k, input req_rec_t e);
        if (k >= got.size()) begin
            check({tag, "_missing"}, 64'(got.size()), 64'(k + 1));
        end else begin
            check({tag, "_r_addr"},  64'(got[k].r_addr),  64'(e.r_addr));
            check({tag, "_r_size"},  64'(got[k].r_size),  64'(e.r_size));
            check({tag, "_r_start"}, 64'(got[k].r_start), 64'(e.r_start));
            check({tag, "_r_end"},   64'(got[k].r_end),   64'(e.r_end));
            check({tag, "_w_addr"},  64'(got[k].w_addr),  64'(e.w_addr));
            check({tag, "_w_size"},  64'(got[k].w_size),  64'(e.w_size));
            check({tag, "_en"},      64'(got[k].en),      64'(e.en));
        end
    endtask

    req_rec_t exp_main [4];
    req_rec_t exp_rr   [4];
    req_rec_t exp_wrap [2];

    initial begin
        int cycles;
        int done_before;
        logic [31:0] addr_snap;

        exp_main[0] = '{32'h1000, 17'd1, 4'd4, 4'd11, 32'd0,  16'd8,  16'h0001};
        exp_main[1] = '{32'h1010, 17'd2, 4'd4, 4'd3,  32'd8,  16'd16, 16'h0002};
        exp_main[2] = '{32'h1040, 17'd1, 4'd4, 4'd11, 32'd24, 16'd8,  16'h0004};
        exp_main[3] = '{32'h1050, 17'd2, 4'd4, 4'd3,  32'd32, 16'd16, 16'h0008};
        exp_rr[0]   = '{32'h1000, 17'd1, 4'd4, 4'd11, 32'd0,  16'd8,  16'h0002};
        exp_rr[1]   = '{32'h1010, 17'd2, 4'd4, 4'd3,  32'd8,  16'd16, 16'h0008};
        exp_rr[2]   = '{32'h1040, 17'd1, 4'd4, 4'd11, 32'd24, 16'd8,  16'h0002};
        exp_rr[3]   = '{32'h1050, 17'd2, 4'd4, 4'd3,  32'd32, 16'd16, 16'h0008};
        exp_wrap[0] = '{32'h0000, 17'd1, 4'd8, 4'd11, 32'd0,  16'd4,  16'h0001};
        exp_wrap[1] = '{32'h0040, 17'd1, 4'd8, 4'd11, 32'd4,  16'd4,  16'h0002};

        i_rst = 1'b1; i_abort = 1'b0; i_start = 1'b0; i_ready = '0;
        configure(32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 11'h0);
        do_reset();

        check("rst_busy",   64'(o_busy),   64'd0);
        check("rst_done",   64'(o_done),   64'd0);
        check("rst_en",     64'(o_en),     64'd0);
        check("rst_r_addr", 64'(o_r_addr), 64'd0);
        check("rst_r_size", 64'(o_r_size), 64'd0);

        // Basic two-row, two-column walk with all trackers ready.
        i_ready = 16'hFFFF;
        configure(32'h1000, 32'd64, 32'd2, 16'd4, 16'd8, 16'd20, 16'd16, 11'b101);
        got.delete(); done_count = 0;
        pulse_start();
        check("busy_after_start", 64'(o_busy), 64'd1);
        wait_done("main_timeout");
        check("main_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4; k++) cmp_req("main", k, exp_main[k]);
        check("main_done_once", 64'(done_count), 64'd1);
        check("main_idle", 64'(o_busy), 64'd0);

        // Round-robin over trackers 1 and 3 from pointer 0.
        do_reset();
        i_ready = 16'b1010;
        got.delete(); done_count = 0;
        pulse_start();
        wait_done("rr_timeout");
        check("rr_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4; k++) cmp_req("rr", k, exp_rr[k]);

        // Backpressure: hold ISSUE with no ready tracker, then release tracker 7.
        do_reset();
        i_ready = '0;
        configure(32'h1000, 32'd64, 32'd1, 16'd4, 16'd8, 16'd0, 16'd0, 11'b001);
        got.delete(); en_count = 0;
        pulse_start();
        cycles = 0;
        while (o_r_size == '0 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 20) check("bp_reach_issue", 64'(o_r_size), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check("bp_no_en",  64'(o_en),     64'd0);
            check("bp_r_addr", 64'(o_r_addr), 64'h1000);
            check("bp_r_end",  64'(o_r_end),  64'd11);
            @(negedge clk);
        end
        i_ready = 16'h0080;
        #1;
        check("bp_en7", 64'(o_en), 64'h0080);
        wait_done("bp_timeout");
        check("bp_count", 64'(en_count), 64'd1);

        // Degenerate configurations: row_cnt=0 and col_en=0.
        for (int t = 0; t < 2; t++) begin
            i_ready = 16'hFFFF;
            if (t == 0) configure(32'h1000, 32'd64, 32'd0, 16'd4, 16'd8, 16'd20, 16'd16, 11'b101);
            else        configure(32'h1000, 32'd64, 32'd2, 16'd4, 16'd8, 16'd20, 16'd16, 11'b000);
            en_count = 0;
            @(negedge clk);
            i_start = 1'b1;
            cycles = 0;
            do begin
                @(negedge clk);
                i_start = 1'b0;
                cycles++;
            end while (!o_done && cycles < 20);
            check(t == 0 ? "deg_rows_latency" : "deg_cols_latency", 64'(cycles), 64'd3);
            check(t == 0 ? "deg_rows_no_en" : "deg_cols_no_en", 64'(en_count), 64'd0);
            @(negedge clk);
        end

        // Abort after the second grant, then restart cleanly.
        do_reset();
        i_ready = 16'hFFFF;
        configure(32'h1000, 32'd64, 32'd2, 16'd4, 16'd8, 16'd20, 16'd16, 11'b101);
        en_count = 0; done_count = 0;
        pulse_start();
        wait_en_count(2, "abort_wait_grant");
        i_abort = 1'b1;
        @(negedge clk);
        check("abort_busy",   64'(o_busy),   64'd0);
        check("abort_en",     64'(o_en),     64'd0);
        check("abort_done",   64'(o_done),   64'd0);
        check("abort_r_addr", 64'(o_r_addr), 64'd0);
        check("abort_w_addr", 64'(o_w_addr), 64'd0);
        check("abort_w_size", 64'(o_w_size), 64'd0);
        i_abort = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_done", 64'(done_count), 64'd0);
        got.delete();
        pulse_start();
        wait_done("restart_timeout");
        check("restart_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4; k++) cmp_req("restart", k, exp_main[k]);

        // Address wrap plus an ignored mid-walk start with changed config.
        do_reset();
        configure(32'hFFFF_FFF0, 32'h40, 32'd2, 16'h18, 16'd4, 16'd0, 16'd0, 11'b001);
        got.delete(); en_count = 0; done_count = 0;
        pulse_start();
        wait_en_count(1, "wrap_wait_grant");
        i_start = 1'b1;
        i_frame_base = 32'h5000;
        @(negedge clk);
        i_start = 1'b0;
        done_before = done_count;
        wait_done("wrap_timeout");
        check("wrap_count", 64'(got.size()), 64'd2);
        for (int k = 0; k < 2; k++) cmp_req("wrap", k, exp_wrap[k]);
        check("wrap_done_once", 64'(done_count - done_before), 64'd1);
        addr_snap = o_r_addr;
        repeat (4) @(negedge clk);
        check("wrap_stays_idle", 64'(o_busy), 64'd0);
        check("wrap_addr_held", 64'(o_r_addr), 64'(addr_snap));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
